// File: rtl/step_counter.sv
// step_counter
//   Upstream stage of the pedometer distance block. Synchronises the raw step
//   pulse, detects its rising edges, accumulates a saturating step count under
//   an IDLE/RUN/PAUSE mode FSM and measures steps per one-second window.
//
// Ports
//   clk            in   system clock, all logic on the rising edge
//   reset_n        in   asynchronous active-low reset
//   step_in        in   asynchronous step pulse (>=2 cycles high, >=2 low)
//   start          in   synchronous; each rising edge toggles run/pause
//   clear          in   synchronous active-high; back to IDLE, counts zeroed
//   stepcount      out  accumulated steps, saturating at SAT_MAX
//   steps_per_sec  out  steps in the last completed window, saturating at 255
//   step_valid     out  one-cycle strobe whenever stepcount changes
//   sat            out  sticky, set when stepcount reaches SAT_MAX
//   running        out  high while the FSM is in RUN
//   state_dbg      out  current FSM state, for observation only
//
// Handshake: there is no valid/ready pair. step_valid is a pure strobe that
// qualifies the stepcount value present in the same cycle; no back-pressure.

module step_counter #(
   parameter int unsigned TICK_CYCLES = 100000000,
   parameter int unsigned SAT_MAX     = 9999
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        step_in,
   input  logic        start,
   input  logic        clear,
   output logic [15:0] stepcount,
   output logic [7:0]  steps_per_sec,
   output logic        step_valid,
   output logic        sat,
   output logic        running,
   output logic [1:0]  state_dbg
);

   localparam logic [1:0] STATE_IDLE  = 2'd0;
   localparam logic [1:0] STATE_RUN   = 2'd1;
   localparam logic [1:0] STATE_PAUSE = 2'd2;

   localparam logic [15:0] SAT_LIMIT = SAT_MAX[15:0];
   localparam logic [31:0] TICK_LAST = TICK_CYCLES - 32'd1;

   // step_in synchroniser and edge history; deliberately untouched by clear
   logic        sync0_q, sync1_q, prev_q;
   logic        start_q;
   logic [1:0]  state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [7:0]  sps_q, sps_d;
   logic [7:0]  win_q, win_d;
   logic [31:0] tick_q, tick_d;
   logic        valid_q, valid_d;
   logic        sat_q, sat_d;
   logic        running_q, running_d;

   logic        step_edge;
   logic        start_edge;
   logic [7:0]  win_inc;

   assign step_edge  = sync1_q & ~prev_q;
   assign start_edge = start & ~start_q;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      sps_d   = sps_q;
      win_d   = win_q;
      tick_d  = tick_q;
      valid_d = 1'b0;
      sat_d   = sat_q;
      win_inc = win_q;

      if (clear) begin
         // clear wins over start_edge and drops any coincident step edge
         state_d = STATE_IDLE;
         count_d = '0;
         sps_d   = '0;
         win_d   = '0;
         tick_d  = '0;
         sat_d   = 1'b0;
      end else begin
         case (state_q)
            STATE_IDLE:  if (start_edge) state_d = STATE_RUN;
            STATE_RUN:   if (start_edge) state_d = STATE_PAUSE;
            STATE_PAUSE: if (start_edge) state_d = STATE_RUN;
            default:     state_d = STATE_IDLE;
         endcase

         // Counting keys off the current state, so an edge in the cycle that
         // enters RUN is not counted, while one in the cycle leaving RUN is.
         if (state_q == STATE_RUN) begin
            if (step_edge && (count_q != SAT_LIMIT)) begin
               count_d = count_q + 16'd1;
               valid_d = 1'b1;
               if ((count_q + 16'd1) == SAT_LIMIT) sat_d = 1'b1;
            end

            // window count ignores stepcount saturation, caps at 255
            if (step_edge && (win_q != 8'hFF)) win_inc = win_q + 8'd1;

            if (tick_q == TICK_LAST) begin
               sps_d  = win_inc;
               win_d  = '0;
               tick_d = '0;
            end else begin
               win_d  = win_inc;
               tick_d = tick_q + 32'd1;
            end
         end
      end

      running_d = (state_d == STATE_RUN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync0_q <= 1'b0;
         sync1_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync0_q <= step_in;
         sync1_q <= sync0_q;
         prev_q  <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_q   <= 1'b0;
         state_q   <= STATE_IDLE;
         count_q   <= '0;
         sps_q     <= '0;
         win_q     <= '0;
         tick_q    <= '0;
         valid_q   <= 1'b0;
         sat_q     <= 1'b0;
         running_q <= 1'b0;
      end else begin
         start_q   <= start;
         state_q   <= state_d;
         count_q   <= count_d;
         sps_q     <= sps_d;
         win_q     <= win_d;
         tick_q    <= tick_d;
         valid_q   <= valid_d;
         sat_q     <= sat_d;
         running_q <= running_d;
      end
   end

   assign stepcount     = count_q;
   assign steps_per_sec = sps_q;
   assign step_valid    = valid_q;
   assign sat           = sat_q;
   assign running       = running_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_step_counter.sv
// Bench for step_counter. Two instances share one stimulus stream:
// dut_a has a 9999 ceiling, dut_b a ceiling of 4; both use a 10-cycle window.
module tb_step_counter;

   localparam int TICK  = 10;
   localparam int SAT_A = 9999;
   localparam int SAT_B = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic step_in = 1'b0;
   logic start = 1'b0;
   logic clear = 1'b0;

   logic [15:0] sc_a, sc_b;
   logic [7:0]  sps_a, sps_b;
   logic        sv_a, sv_b, sat_a, sat_b, run_a, run_b;
   logic [1:0]  st_a, st_b;

   always #5 clk = ~clk;

   step_counter #(.TICK_CYCLES(TICK), .SAT_MAX(SAT_A)) dut_a (
      .clk(clk), .reset_n(reset_n), .step_in(step_in), .start(start), .clear(clear),
      .stepcount(sc_a), .steps_per_sec(sps_a), .step_valid(sv_a), .sat(sat_a),
      .running(run_a), .state_dbg(st_a));

   step_counter #(.TICK_CYCLES(TICK), .SAT_MAX(SAT_B)) dut_b (
      .clk(clk), .reset_n(reset_n), .step_in(step_in), .start(start), .clear(clear),
      .stepcount(sc_b), .steps_per_sec(sps_b), .step_valid(sv_b), .sat(sat_b),
      .running(run_b), .state_dbg(st_b));

   int checks = 0;
   int failures = 0;

   // scoreboard: expected stepcount value for each step_valid strobe
   logic [15:0] exp_qa[$];
   logic [15:0] exp_qb[$];
   int model_a = 0;
   int model_b = 0;
   bit exp_run = 1'b0;

   typedef struct {
      int op;      // 0 = start pulse, 1 = step (3 high / 3 low), 2 = clear
      int sc_a;
      int sc_b;
      bit run;
      bit sat_b;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_step();
      if (exp_run) begin
         if (model_a < SAT_A) begin
            model_a++;
            exp_qa.push_back(16'(model_a));
         end
         if (model_b < SAT_B) begin
            model_b++;
            exp_qb.push_back(16'(model_b));
         end
      end
   endtask

   task automatic do_step(input int hi, input int lo);
      model_step();
      step_in = 1'b1;
      tick(hi);
      step_in = 1'b0;
      tick(lo);
   endtask

   task automatic pulse_start(input int hold);
      start = 1'b1;
      tick(hold);
      start = 1'b0;
      tick(1);
      exp_run = !exp_run;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      tick(1);
      model_a = 0;
      model_b = 0;
      exp_run = 1'b0;
   endtask

   task automatic drain(input string tag);
      chk({tag, "_strobes_missing_a"}, exp_qa.size(), 0);
      chk({tag, "_strobes_missing_b"}, exp_qb.size(), 0);
      exp_qa.delete();
      exp_qb.delete();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
      model_a = 0;
      model_b = 0;
      exp_run = 1'b0;
   endtask

   // pop an expected value whenever a DUT strobes step_valid
   always @(negedge clk) begin
      if (reset_n) begin
         if (sv_a) begin
            if (exp_qa.size() == 0) chk("extra_strobe_a", 1, 0);
            else chk("strobe_value_a", sc_a, exp_qa.pop_front());
         end
         if (sv_b) begin
            if (exp_qb.size() == 0) chk("extra_strobe_b", 1, 0);
            else chk("strobe_value_b", sc_b, exp_qb.pop_front());
         end
      end
   end

   initial begin
      tbl[0] = '{0, 0, 0, 1'b1, 1'b0};
      tbl[1] = '{1, 1, 1, 1'b1, 1'b0};
      tbl[2] = '{1, 2, 2, 1'b1, 1'b0};
      tbl[3] = '{1, 3, 3, 1'b1, 1'b0};
      tbl[4] = '{1, 4, 4, 1'b1, 1'b1};
      tbl[5] = '{1, 5, 4, 1'b1, 1'b1};
      tbl[6] = '{2, 0, 0, 1'b0, 1'b0};
      tbl[7] = '{1, 0, 0, 1'b0, 1'b0};
      tbl[8] = '{0, 0, 0, 1'b1, 1'b0};

      // ---- reset state
      #2 reset_n = 1'b0;
      tick(3);
      chk("rst_stepcount", sc_a, 0);
      chk("rst_sps", sps_a, 0);
      chk("rst_valid", sv_a, 0);
      chk("rst_sat", sat_a, 0);
      chk("rst_running", run_a, 0);
      chk("rst_state", st_a, 0);
      reset_n = 1'b1;
      tick(2);

      // ---- table: start, 5 steps, clear, step in IDLE, restart
      for (int i = 0; i < 9; i++) begin
         case (tbl[i].op)
            0: pulse_start(1);
            1: do_step(3, 3);
            default: pulse_clear();
         endcase
         chk($sformatf("vec%0d_stepcount_a", i), sc_a, tbl[i].sc_a);
         chk($sformatf("vec%0d_stepcount_b", i), sc_b, tbl[i].sc_b);
         chk($sformatf("vec%0d_running", i), run_a, tbl[i].run);
         chk($sformatf("vec%0d_sat_b", i), sat_b, tbl[i].sat_b);
         chk($sformatf("vec%0d_sat_a", i), sat_a, 0);
         if (tbl[i].op == 2) chk("clear_state_idle", st_b, 0);
      end

      // ---- latency: count moves on the 3rd edge step_in is sampled high
      model_step();
      step_in = 1'b1;
      tick(2);
      chk("latency_edge2", sc_a, 0);
      tick(1);
      chk("latency_edge3", sc_a, 1);
      chk("latency_strobe", sv_a, 1);
      step_in = 1'b0;
      tick(3);
      drain("s1");

      // ---- window: 3 steps in the first 10 RUN cycles, last on the boundary
      do_reset();
      start = 1'b1;
      step_in = 1'b1;
      tick(1);
      exp_run = 1'b1;
      model_step();
      start = 1'b0;
      tick(1);
      step_in = 1'b0;
      tick(2);
      do_step(2, 2);
      model_step();
      step_in = 1'b1;
      tick(2);
      chk("win_before_boundary_sps", sps_a, 0);
      chk("win_before_boundary_count", sc_a, 2);
      step_in = 1'b0;
      tick(1);
      chk("win_boundary_sps", sps_a, 3);
      chk("win_boundary_count", sc_a, 3);
      tick(9);
      chk("win2_hold_sps", sps_a, 3);
      tick(1);
      chk("win2_empty_sps", sps_a, 0);
      drain("s2");

      // ---- pause/resume: tick counter must freeze while paused
      do_reset();
      pulse_start(1);
      do_step(2, 2);
      do_step(2, 2);
      chk("pr_running_run", run_a, 1);
      pulse_start(1);
      for (int i = 0; i < 4; i++) do_step(2, 2);
      chk("pr_paused_count", sc_a, 2);
      chk("pr_paused_running", run_a, 0);
      chk("pr_paused_state", st_a, 2);
      chk("pr_paused_sps", sps_a, 2);
      pulse_start(1);
      do_step(2, 2);
      chk("pr_resumed_count", sc_a, 3);
      chk("pr_resumed_running", run_a, 1);
      tick(4);
      chk("pr_window_hold", sps_a, 2);
      tick(1);
      chk("pr_window_end", sps_a, 1);
      drain("s3");

      // ---- clear + start together in RUN, step edge coincident with clear
      do_reset();
      pulse_start(1);
      do_step(2, 2);
      chk("cs_before", sc_a, 1);
      step_in = 1'b1;
      tick(2);
      clear = 1'b1;
      start = 1'b1;
      tick(1);
      clear = 1'b0;
      start = 1'b0;
      step_in = 1'b0;
      tick(3);
      model_a = 0;
      model_b = 0;
      exp_run = 1'b0;
      chk("cs_count", sc_a, 0);
      chk("cs_running", run_a, 0);
      chk("cs_state", st_a, 0);
      do_step(2, 2);
      chk("cs_idle_step", sc_a, 0);
      drain("s4");

      // ---- held start toggles once; async reset mid-window
      do_reset();
      pulse_start(4);
      chk("hold_start_running", run_a, 1);
      for (int i = 0; i < 7; i++) do_step(2, 2);
      chk("mid_count_a", sc_a, 7);
      chk("mid_count_b", sc_b, 4);
      chk("mid_sat_b", sat_b, 1);
      drain("s5");
      #2 reset_n = 1'b0;
      #1;
      chk("async_count_a", sc_a, 0);
      chk("async_sps_a", sps_a, 0);
      chk("async_sat_b", sat_b, 0);
      chk("async_running", run_a, 0);
      tick(2);
      reset_n = 1'b1;
      model_a = 0;
      model_b = 0;
      exp_run = 1'b0;
      tick(1);
      do_step(2, 2);
      chk("post_reset_idle", sc_a, 0);
      pulse_start(1);
      do_step(2, 2);
      chk("post_reset_count", sc_a, 1);
      drain("s6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
